fft2d_output_router: RTL and testbench
======================================

# fft2d_output_router

Parametrised router at the output of the 1-D FFT core in the 2-D FFT datapath. It captures an N×N complex matrix row by row, returns it transposed to the input selector for the column pass, then captures the column-pass results and emits the final matrix in natural orientation. It replaces the fixed 4×4 combinational output selection with a buffered, handshaked, N-generic block. A 1-D bypass mode is also supported.

## Interface
- N, 4, points per dimension; power of two, ≥2.
- W, 16, signed bit width of each real/imag component.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode_2d  in  1  1 = row pass + column pass; 0 = single pass. Sampled on the first accepted row of a frame.
- in_valid  in  1  row from FFT core is valid.
- in_ready  out  1  router accepts a row.
- in_r, in_i  in  N*W  one row, element k at bits [k*W +: W], signed.
- rt_valid  out  1  transposed row to input selector is valid.
- rt_ready  in  1  input selector accepts.
- rt_r, rt_i  out  N*W  return row, same packing.
- out_valid  out  1  final result row is valid.
- out_ready  in  1  downstream accepts.
- out_r, out_i  out  N*W  final row, same packing.
- busy  out  1  frame in progress (any state other than CAP0 with row_cnt = 0).

## Operation
- Storage: buf[row][col] of N×N complex words, 2·W bits each. Counter cnt is $clog2(N) bits.
- FSM states: CAP0, RET, CAP1, OUT. Reset state: CAP0.
- CAP0:
  - in_ready = 1.
  - On in_valid & in_ready, buf[cnt] ← row and cnt++.
  - The first accepted row latches mode_2d into mode_q.
  - On the N-th row (cnt = N−1): cnt ← 0, then go to RET if mode_q = 1, else to OUT.
- RET:
  - rt_valid = 1; rt row k = buf[k][cnt] (column cnt).
  - On rt_valid & rt_ready, cnt++.
  - At cnt = N−1 with the handshake: cnt ← 0, go to CAP1.
- CAP1: same as CAP0 (no mode latch). After N rows, go to OUT.
- OUT:
  - out_valid = 1.
  - If mode_q = 1: out row element k = buf[k][cnt] (transpose back to natural orientation).
  - If mode_q = 0: out row = buf[cnt] (untransposed).
  - On the handshake cnt++. At cnt = N−1: cnt ← 0, go to CAP0.
- in_ready = 0 in RET and OUT. rt_valid = 0 outside RET. out_valid = 0 outside OUT.
- Handshake rules:
  - valid never depends combinationally on ready.
  - Data is stable while valid is high and ready is low.
  - Data is pure routing: no scaling, rounding or sign change; widths in equal widths out.
- mode_2d changes after the first row of a frame have no effect until the next frame.
- Outputs are registered state decoded from buf and cnt; the rt/out data buses are don't-care while the matching valid is low.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM → CAP0, cnt → 0, mode_q → 1, every buf entry → 0.
  - in_ready = 1, rt_valid = 0, out_valid = 0, busy = 0; data outputs 0.
- Throughput: one row per cycle in the capture states; one row per cycle in the drain states when ready is held high.
- Latency:
  - Last CAP0 row accepted at edge t → rt_valid high from t (after the edge); first rt handshake possible at t+1.
  - Last RET handshake at edge t → in_ready high from t.
  - Same one-cycle turnaround for CAP1→OUT and OUT→CAP0.
- Full 2-D frame with no backpressure: 4N cycles. 1-D frame: 2N cycles.
- Backpressure: rt_ready / out_ready low holds cnt and data indefinitely.
- in_valid while in_ready = 0 is ignored; the core must hold its row.
- Reset mid-frame aborts the frame. No partial output is ever emitted afterwards.

## Test plan
- Reset: assert reset mid-RET → immediately rt_valid = 0, in_ready = 1, busy = 0. After release, a fresh frame routes correctly.
- 2-D identity routing, N=4, W=16:
  - Pass 0: capture rows with element (r,c) = 16·r + c. RET emits row k = {k, 16+k, 32+k, 48+k}.
  - Pass 1: capture rows with element (r,c) = 0x100 + 16·r + c. OUT emits row k = {0x100+k, 0x110+k, 0x120+k, 0x130+k}.
- Backpressure: hold rt_ready = 0 for 5 cycles at cnt = 2 → rt_r / rt_i stay constant, cnt stays 2, no row is lost.
- 1-D bypass: mode_2d = 0, capture rows r = {r, r, r, r} → no rt_valid ever. OUT emits rows 0..3 in order. Total 8 cycles with ready held high.
- Mode latch: mode_2d = 1 on the first row, then 0 on rows 1–3 → the full 2-D sequence still occurs.
- Signed extremes: W=16 inputs 0x8000 / 0x7FFF, including imag parts → values emitted bit-exact on both rt and out paths. Repeat with parameters N=8, W=24.

Source files
------------

// File: rtl/fft2d_output_router.sv
`default_nettype none
// ============================================================================
// Module   : fft2d_output_router
// Brief    : N-generic buffered router at the 1-D FFT core output. It returns
//            rows transposed for the column pass and emits the final matrix.
// Revision : 1.0
// ============================================================================
module fft2d_output_router #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mode_2d,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_r,
  input  logic [N*W-1:0] in_i,
  output logic           rt_valid,
  input  logic           rt_ready,
  output logic [N*W-1:0] rt_r,
  output logic [N*W-1:0] rt_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_r,
  output logic [N*W-1:0] out_i,
  output logic           busy
);

  localparam int                 c_cnt_w = $clog2(N);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);

  typedef enum logic [1:0] {
    CAP0 = 2'd0,
    RET  = 2'd1,
    CAP1 = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_mode;
  logic [W-1:0]         r_buf_r [N][N];
  logic [W-1:0]         r_buf_i [N][N];

  logic                 w_in_fire;
  logic                 w_last;

  // Handshake flags decode only from the state register, never from ready.
  assign in_ready  = (r_state == CAP0) || (r_state == CAP1);
  assign rt_valid  = (r_state == RET);
  assign out_valid = (r_state == OUT);
  assign busy      = (r_state != CAP0) || (r_cnt != '0);

  assign w_in_fire = in_valid & in_ready;
  assign w_last    = (r_cnt == c_last);

  // Return path reads column r_cnt; the output path reads a column after a
  // 2-D frame (undoing the transpose) or row r_cnt after a 1-D frame.
  generate
    for (genvar k = 0; k < N; k++) begin : g_lane
      assign rt_r[k*W +: W]  = r_buf_r[k][r_cnt];
      assign rt_i[k*W +: W]  = r_buf_i[k][r_cnt];
      assign out_r[k*W +: W] = r_mode ? r_buf_r[k][r_cnt] : r_buf_r[r_cnt][k];
      assign out_i[k*W +: W] = r_mode ? r_buf_i[k][r_cnt] : r_buf_i[r_cnt][k];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CAP0;
      r_cnt   <= '0;
      r_mode  <= 1'b1;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_buf_r[r][c] <= '0;
          r_buf_i[r][c] <= '0;
        end
      end
    end else begin
      if (w_in_fire) begin
        for (int k = 0; k < N; k++) begin
          r_buf_r[r_cnt][k] <= in_r[k*W +: W];
          r_buf_i[r_cnt][k] <= in_i[k*W +: W];
        end
      end

      case (r_state)
        CAP0: begin
          if (w_in_fire) begin
            if (r_cnt == '0) begin
              r_mode <= mode_2d;
            end
            // N >= 2, so the frame mode is already latched on the last row.
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= r_mode ? RET : OUT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        RET: begin
          if (rt_ready) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= CAP1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        CAP1: begin
          if (w_in_fire) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= OUT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= CAP0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= CAP0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft2d_output_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft2d_output_router
// Brief    : Self-checking bench for fft2d_output_router (N=4/W=16, N=8/W=24).
// Revision : 1.0
// ============================================================================
module tb_fft2d_output_router;

  localparam int NA   = 4;
  localparam int WA   = 16;
  localparam int NB   = 8;
  localparam int WB   = 24;
  localparam int MAXB = NB * WB;

  typedef struct {
    int sel;        // 0: N=4/W=16 instance, 1: N=8/W=24 instance
    bit mf;         // mode_2d on the first row
    bit mr;         // mode_2d on the remaining rows
    int pat;        // 0 identity, 1 row-constant, 2 signed extremes, 3 random
    int rt_row;     // rt handshake index where rt_ready drops
    int rt_len;
    int out_row;    // out handshake index where out_ready drops
    int out_len;
    bit junk;       // drive in_valid with garbage while draining
    int exp_cycles; // frame length from first row to last output handshake
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              mode_a = 1'b0, inv_a = 1'b0, rtrdy_a = 1'b0, outrdy_a = 1'b0;
  logic [NA*WA-1:0]  inr_a = '0, ini_a = '0;
  logic              inrdy_a, rtv_a, outv_a, busy_a;
  logic [NA*WA-1:0]  rtr_a, rti_a, outr_a, outi_a;

  logic              mode_b = 1'b0, inv_b = 1'b0, rtrdy_b = 1'b0, outrdy_b = 1'b0;
  logic [NB*WB-1:0]  inr_b = '0, ini_b = '0;
  logic              inrdy_b, rtv_b, outv_b, busy_b;
  logic [NB*WB-1:0]  rtr_b, rti_b, outr_b, outi_b;

  fft2d_output_router #(.N(NA), .W(WA)) dut_a (
    .clk(clk), .reset(reset), .mode_2d(mode_a),
    .in_valid(inv_a), .in_ready(inrdy_a), .in_r(inr_a), .in_i(ini_a),
    .rt_valid(rtv_a), .rt_ready(rtrdy_a), .rt_r(rtr_a), .rt_i(rti_a),
    .out_valid(outv_a), .out_ready(outrdy_a), .out_r(outr_a), .out_i(outi_a),
    .busy(busy_a)
  );

  fft2d_output_router #(.N(NB), .W(WB)) dut_b (
    .clk(clk), .reset(reset), .mode_2d(mode_b),
    .in_valid(inv_b), .in_ready(inrdy_b), .in_r(inr_b), .in_i(ini_b),
    .rt_valid(rtv_b), .rt_ready(rtrdy_b), .rt_r(rtr_b), .rt_i(rti_b),
    .out_valid(outv_b), .out_ready(outrdy_b), .out_r(outr_b), .out_i(outi_b),
    .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;

  logic [MAXB-1:0] q_rt_r[$], q_rt_i[$], q_out_r[$], q_out_i[$];
  logic [WB-1:0]   m_r [2][NB][NB];
  logic [WB-1:0]   m_i [2][NB][NB];
  vec_t            vecs [10];

  task automatic chk(input string name, input logic [MAXB-1:0] act, input logic [MAXB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [MAXB-1:0] r,
                        input logic [MAXB-1:0] i, input logic md);
    if (sel == 0) begin
      inv_a = v; inr_a = r[NA*WA-1:0]; ini_a = i[NA*WA-1:0]; mode_a = md;
    end else begin
      inv_b = v; inr_b = r[NB*WB-1:0]; ini_b = i[NB*WB-1:0]; mode_b = md;
    end
  endtask

  task automatic set_rdy(input int sel, input int which, input logic rdy);
    if (sel == 0) begin
      rtrdy_a = (which == 0) && rdy; outrdy_a = (which == 1) && rdy;
    end else begin
      rtrdy_b = (which == 0) && rdy; outrdy_b = (which == 1) && rdy;
    end
  endtask

  // which=0 observes the return path, which=1 the output path.
  task automatic sample(input int sel, input int which, output logic v, output logic other,
                        output logic b, output logic rin,
                        output logic [MAXB-1:0] dr, output logic [MAXB-1:0] di);
    if (sel == 0) begin
      v     = (which == 1) ? outv_a : rtv_a;
      other = (which == 1) ? rtv_a  : outv_a;
      b     = busy_a;
      rin   = inrdy_a;
      dr    = (which == 1) ? MAXB'(outr_a) : MAXB'(rtr_a);
      di    = (which == 1) ? MAXB'(outi_a) : MAXB'(rti_a);
    end else begin
      v     = (which == 1) ? outv_b : rtv_b;
      other = (which == 1) ? rtv_b  : outv_b;
      b     = busy_b;
      rin   = inrdy_b;
      dr    = (which == 1) ? MAXB'(outr_b) : MAXB'(rtr_b);
      di    = (which == 1) ? MAXB'(outi_b) : MAXB'(rti_b);
    end
  endtask

  task automatic fill(input int sel, input int pat);
    int n, w;
    logic [WB-1:0] mask, mn, mx, re, im;
    n    = (sel != 0) ? NB : NA;
    w    = (sel != 0) ? WB : WA;
    mask = WB'((64'd1 << w) - 64'd1);
    mn   = WB'(64'd1 << (w - 1));
    mx   = mn - 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          case (pat)
            0: begin re = WB'(p*256 + 16*r + c); im = ~re; end
            1: begin re = WB'(p*256 + r);        im = ~re; end
            2: begin re = ((r + c + p) % 2 != 0) ? mx : mn; im = ((r + c + p) % 2 != 0) ? mn : mx; end
            default: begin re = WB'($urandom); im = WB'($urandom); end
          endcase
          m_r[p][r][c] = re & mask;
          m_i[p][r][c] = im & mask;
        end
      end
    end
  endtask

  // Row k of pass p; with tr set, lane j holds element (j,k) instead of (k,j).
  function automatic logic [MAXB-1:0] rowpack(input int sel, input int p, input int k,
                                             input bit im, input bit tr);
    int n, w;
    logic [MAXB-1:0] row;
    logic [WB-1:0]   val;
    n   = (sel != 0) ? NB : NA;
    w   = (sel != 0) ? WB : WA;
    row = '0;
    for (int j = 0; j < n; j++) begin
      if (tr) val = im ? m_i[p][j][k] : m_r[p][j][k];
      else    val = im ? m_i[p][k][j] : m_r[p][k][j];
      row = row | (MAXB'(val) << (j * w));
    end
    return row;
  endfunction

  task automatic capture(input int sel, input int p, input bit mf, input bit mr, inout int cycles);
    int n, r, budget;
    logic v, other, b, rin;
    logic [MAXB-1:0] dr, di;
    n = (sel != 0) ? NB : NA;
    r = 0;
    budget = 0;
    while (r < n && budget < 200) begin
      set_in(sel, 1'b1, rowpack(sel, p, r, 1'b0, 1'b0), rowpack(sel, p, r, 1'b1, 1'b0),
             (r == 0) ? mf : mr);
      @(negedge clk);
      sample(sel, 0, v, other, b, rin, dr, di);
      chk("cap_in_ready", MAXB'(rin), 1);
      chk("cap_valids", MAXB'(v | other), 0);
      @(posedge clk); #1;
      cycles++;
      budget++;
      if (rin) r++;
    end
    if (r < n) chk("cap_timeout", MAXB'(r), MAXB'(n));
    set_in(sel, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic drain(input int sel, input int which, input int max_hs, input int st_row,
                       input int st_len, input bit junk, inout int cycles);
    int hs, left, budget;
    logic v, other, b, rin, rdy;
    logic [MAXB-1:0] dr, di, er, ei;
    hs = 0;
    left = st_len;
    budget = 0;
    while (hs < max_hs && budget < 200) begin
      rdy = !(hs == st_row && left > 0);
      set_rdy(sel, which, rdy);
      if (junk) set_in(sel, 1'b1, MAXB'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}),
                       MAXB'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}), 1'b0);
      @(negedge clk);
      sample(sel, which, v, other, b, rin, dr, di);
      chk((which == 1) ? "out_valid" : "rt_valid", MAXB'(v), 1);
      chk("drain_exclusive", MAXB'(other | rin), 0);
      chk("drain_busy", MAXB'(b), 1);
      if (v) begin
        er = (which == 1) ? q_out_r[0] : q_rt_r[0];
        ei = (which == 1) ? q_out_i[0] : q_rt_i[0];
        chk((which == 1) ? "out_r" : "rt_r", dr, er);
        chk((which == 1) ? "out_i" : "rt_i", di, ei);
        if (rdy) begin
          if (which == 1) begin void'(q_out_r.pop_front()); void'(q_out_i.pop_front()); end
          else            begin void'(q_rt_r.pop_front());  void'(q_rt_i.pop_front());  end
          hs++;
        end
      end
      if (!rdy) left--;
      @(posedge clk); #1;
      cycles++;
      budget++;
    end
    if (hs < max_hs) chk("drain_timeout", MAXB'(hs), MAXB'(max_hs));
    set_rdy(sel, which, 1'b0);
    set_in(sel, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n, cycles;
    logic vv, other, b, rin;
    logic [MAXB-1:0] dr, di;
    n = (v.sel != 0) ? NB : NA;
    cycles = 0;
    fill(v.sel, v.pat);
    capture(v.sel, 0, v.mf, v.mr, cycles);
    if (v.mf) begin
      for (int k = 0; k < n; k++) begin
        q_rt_r.push_back(rowpack(v.sel, 0, k, 1'b0, 1'b1));
        q_rt_i.push_back(rowpack(v.sel, 0, k, 1'b1, 1'b1));
      end
      drain(v.sel, 0, n, v.rt_row, v.rt_len, v.junk, cycles);
      // The opposite mode during the column pass must not be latched.
      capture(v.sel, 1, !v.mf, !v.mf, cycles);
      for (int k = 0; k < n; k++) begin
        q_out_r.push_back(rowpack(v.sel, 1, k, 1'b0, 1'b1));
        q_out_i.push_back(rowpack(v.sel, 1, k, 1'b1, 1'b1));
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        q_out_r.push_back(rowpack(v.sel, 0, k, 1'b0, 1'b0));
        q_out_i.push_back(rowpack(v.sel, 0, k, 1'b1, 1'b0));
      end
    end
    drain(v.sel, 1, n, v.out_row, v.out_len, v.junk, cycles);
    chk($sformatf("vec%0d_cycles", idx), MAXB'(cycles), MAXB'(v.exp_cycles));
    @(negedge clk);
    sample(v.sel, 1, vv, other, b, rin, dr, di);
    chk($sformatf("vec%0d_idle", idx), MAXB'({vv, other, b, rin}), 4'b0001);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before 300000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic v, other, b, rin;
    logic [MAXB-1:0] dr, di;
    int cyc;

    //              sel mf    mr    pat rt_row len out_row len junk  cycles
    vecs[0] = '{0, 1'b1, 1'b1, 0, -1, 0, -1, 0, 1'b0, 16};
    vecs[1] = '{0, 1'b1, 1'b1, 0,  2, 5, -1, 0, 1'b1, 21};
    vecs[2] = '{0, 1'b0, 1'b0, 1, -1, 0, -1, 0, 1'b0, 8};
    vecs[3] = '{0, 1'b1, 1'b0, 0, -1, 0, -1, 0, 1'b0, 16};
    vecs[4] = '{0, 1'b1, 1'b1, 2, -1, 0,  1, 3, 1'b0, 19};
    vecs[5] = '{0, 1'b0, 1'b0, 3, -1, 0,  3, 2, 1'b1, 10};
    vecs[6] = '{1, 1'b1, 1'b1, 2, -1, 0, -1, 0, 1'b0, 32};
    vecs[7] = '{1, 1'b0, 1'b0, 3, -1, 0,  0, 4, 1'b0, 20};
    vecs[8] = '{0, 1'b0, 1'b1, 0, -1, 0, -1, 0, 1'b0, 8};
    vecs[9] = '{0, 1'b1, 1'b1, 3,  0, 2,  3, 1, 1'b1, 19};

    // Values held during reset.
    #3;
    sample(0, 0, v, other, b, rin, dr, di);
    chk("reset_flags", MAXB'({v, other, b, rin}), 4'b0001);
    chk("reset_rt_data", dr | di, 0);
    sample(0, 1, v, other, b, rin, dr, di);
    chk("reset_out_data", dr | di, 0);
    sample(1, 0, v, other, b, rin, dr, di);
    chk("reset_flags_b", MAXB'({v, other, b, rin}), 4'b0001);
    @(posedge clk); #1;
    reset = 1'b0;

    // Abort a frame in the middle of the return pass.
    cyc = 0;
    fill(0, 0);
    capture(0, 0, 1'b1, 1'b1, cyc);
    for (int k = 0; k < NA; k++) begin
      q_rt_r.push_back(rowpack(0, 0, k, 1'b0, 1'b1));
      q_rt_i.push_back(rowpack(0, 0, k, 1'b1, 1'b1));
    end
    drain(0, 0, 2, -1, 0, 1'b0, cyc);
    #2 reset = 1'b1;
    #1;
    sample(0, 0, v, other, b, rin, dr, di);
    chk("midret_rt_valid", MAXB'(v), 0);
    chk("midret_in_ready", MAXB'(rin), 1);
    chk("midret_busy", MAXB'(b), 0);
    chk("midret_out_valid", MAXB'(other), 0);
    chk("midret_rt_data", dr | di, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    q_rt_r.delete(); q_rt_i.delete(); q_out_r.delete(); q_out_i.delete();

    for (int t = 0; t < 10; t++) begin
      run_vec(vecs[t], t);
    end

    chk("queues_empty", MAXB'(q_rt_r.size() + q_out_r.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
